// File: rtl/conv_tile_scheduler.sv
// Tile sequencer for one convolution layer on a square systolic array.
// Walks filter groups, then output rows, then column tiles, one descriptor in flight at a time.
module conv_tile_scheduler #(
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned IFM_SIZE      = 26,
  parameter int unsigned KERNEL_SIZE   = 1,
  parameter int unsigned NO_FILTER     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic [15:0] tile_row,
  output logic [15:0] tile_col_base,
  output logic [15:0] tile_cols,
  output logic [15:0] filter_base,
  output logic [15:0] filter_cnt,
  output logic [15:0] count_tiling,
  output logic [15:0] count_filter,
  input  logic        tile_done,
  output logic        busy,
  output logic        done
);

  localparam int unsigned OFM_SIZE_CONV      = IFM_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned NO_TILING_PER_LINE = (OFM_SIZE_CONV + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int unsigned NO_TILING          = NO_TILING_PER_LINE * OFM_SIZE_CONV;
  localparam int unsigned NO_FILTER_GROUP    = (NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;

  localparam logic [15:0] SIZE_W = 16'(SYSTOLIC_SIZE);
  localparam logic [15:0] OFM_W  = 16'(OFM_SIZE_CONV);
  localparam logic [15:0] TPL_W  = 16'(NO_TILING_PER_LINE);
  localparam logic [15:0] NT_W   = 16'(NO_TILING);
  localparam logic [15:0] NFG_W  = 16'(NO_FILTER_GROUP);
  localparam logic [15:0] NF_W   = 16'(NO_FILTER);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFin} state_e;

  state_e      state_q, state_d;
  logic [15:0] col_q, col_d, row_q, row_d;
  logic [15:0] tiling_q, tiling_d, filter_q, filter_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        load;
  logic        last_tile;
  logic [15:0] col_base_d, fbase_d;
  logic [15:0] col_base_q, cols_q, fbase_q, fcnt_q;

  // Remaining extent from base, capped at one array width.
  function automatic logic [15:0] clamp_fill(input logic [15:0] total, input logic [15:0] base);
    logic [15:0] rem;
    rem = total - base;
    return (rem > SIZE_W) ? SIZE_W : rem;
  endfunction

  assign last_tile = (tiling_q == NT_W - 16'd1) && (filter_q == NFG_W - 16'd1);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    tiling_d = tiling_q;
    filter_d = filter_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          col_d    = '0;
          row_d    = '0;
          tiling_d = '0;
          filter_d = '0;
          busy_d   = 1'b1;
          load     = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (tile_ready) state_d = StWait;
      end
      StWait: begin
        if (tile_done) begin
          if (last_tile) begin
            // Counters keep the final tile's values through FIN.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StFin;
          end else begin
            load     = 1'b1;
            state_d  = StIssue;
            tiling_d = tiling_q + 16'd1;
            col_d    = col_q + 16'd1;
            if (col_q + 16'd1 == TPL_W) begin
              col_d = '0;
              row_d = row_q + 16'd1;
              if (row_q + 16'd1 == OFM_W) begin
                row_d    = '0;
                tiling_d = '0;
                filter_d = filter_q + 16'd1;
              end
            end
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign col_base_d = col_d * SIZE_W;
  assign fbase_d    = filter_d * SIZE_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      tiling_q   <= '0;
      filter_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      col_base_q <= '0;
      cols_q     <= '0;
      fbase_q    <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      tiling_q <= tiling_d;
      filter_q <= filter_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (load) begin
        col_base_q <= col_base_d;
        cols_q     <= clamp_fill(OFM_W, col_base_d);
        fbase_q    <= fbase_d;
        fcnt_q     <= clamp_fill(NF_W, fbase_d);
      end
    end
  end

  assign tile_valid    = (state_q == StIssue);
  assign tile_row      = row_q;
  assign tile_col_base = col_base_q;
  assign tile_cols     = cols_q;
  assign filter_base   = fbase_q;
  assign filter_cnt    = fcnt_q;
  assign count_tiling  = tiling_q;
  assign count_filter  = filter_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Bench for conv_tile_scheduler: default layer plus a 16/3/32 layer, checked against
// a descriptor list generated from nested group/row/column loops.
module tb_conv_tile_scheduler;

  typedef struct {
    int row;
    int colb;
    int cols;
    int fb;
    int fc;
    int tiling;
    int grp;
  } desc_t;

  logic        clk, rst_n;
  logic        start, tile_ready, tile_done;
  logic        tile_valid, busy, done;
  logic [15:0] tile_row, tile_col_base, tile_cols, filter_base, filter_cnt;
  logic [15:0] count_tiling, count_filter;

  logic        b_start, b_tile_ready, b_tile_done;
  logic        b_tile_valid, b_busy, b_done;
  logic [15:0] b_tile_row, b_tile_col_base, b_tile_cols, b_filter_base, b_filter_cnt;
  logic [15:0] b_count_tiling, b_count_filter;

  int    checks = 0;
  int    failures = 0;
  desc_t model_q[$];
  desc_t exp_a[$];
  desc_t exp_b[$];

  conv_tile_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .tile_valid    (tile_valid),
    .tile_ready    (tile_ready),
    .tile_row      (tile_row),
    .tile_col_base (tile_col_base),
    .tile_cols     (tile_cols),
    .filter_base   (filter_base),
    .filter_cnt    (filter_cnt),
    .count_tiling  (count_tiling),
    .count_filter  (count_filter),
    .tile_done     (tile_done),
    .busy          (busy),
    .done          (done)
  );

  conv_tile_scheduler #(
    .SYSTOLIC_SIZE (16),
    .IFM_SIZE      (16),
    .KERNEL_SIZE   (3),
    .NO_FILTER     (32)
  ) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (b_start),
    .tile_valid    (b_tile_valid),
    .tile_ready    (b_tile_ready),
    .tile_row      (b_tile_row),
    .tile_col_base (b_tile_col_base),
    .tile_cols     (b_tile_cols),
    .filter_base   (b_filter_base),
    .filter_cnt    (b_filter_cnt),
    .count_tiling  (b_count_tiling),
    .count_filter  (b_count_filter),
    .tile_done     (b_tile_done),
    .busy          (b_busy),
    .done          (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Expected issue order: groups outermost, then rows, then column tiles.
  task automatic build_model(input int s, input int ifm, input int k, input int nf);
    int ofm, tpl, nfg;
    desc_t d;
    model_q.delete();
    ofm = ifm - k + 1;
    tpl = (ofm + s - 1) / s;
    nfg = (nf + s - 1) / s;
    for (int g = 0; g < nfg; g++)
      for (int r = 0; r < ofm; r++)
        for (int c = 0; c < tpl; c++) begin
          d.row    = r;
          d.colb   = c * s;
          d.cols   = (ofm - c * s < s) ? ofm - c * s : s;
          d.fb     = g * s;
          d.fc     = (nf - g * s < s) ? nf - g * s : s;
          d.tiling = r * tpl + c;
          d.grp    = g;
          model_q.push_back(d);
        end
  endtask

  task automatic chk_desc(input int idx);
    chk($sformatf("row[%0d]", idx), tile_row, exp_a[idx].row);
    chk($sformatf("col_base[%0d]", idx), tile_col_base, exp_a[idx].colb);
    chk($sformatf("cols[%0d]", idx), tile_cols, exp_a[idx].cols);
    chk($sformatf("filter_base[%0d]", idx), filter_base, exp_a[idx].fb);
    chk($sformatf("filter_cnt[%0d]", idx), filter_cnt, exp_a[idx].fc);
    chk($sformatf("count_tiling[%0d]", idx), count_tiling, exp_a[idx].tiling);
    chk($sformatf("count_filter[%0d]", idx), count_filter, exp_a[idx].grp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, tile_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_row"}, tile_row, 0);
    chk({tag, "_col_base"}, tile_col_base, 0);
    chk({tag, "_cols"}, tile_cols, 0);
    chk({tag, "_filter_base"}, filter_base, 0);
    chk({tag, "_filter_cnt"}, filter_cnt, 0);
    chk({tag, "_count_tiling"}, count_tiling, 0);
    chk({tag, "_count_filter"}, count_filter, 0);
  endtask

  // One layer on the default instance. Called with the DUT idle, at posedge+1.
  task automatic run_a(input int ready_pct, input int fixed_delay, input int spur_pct,
                       input int stall_idx, input int abuse_idx, input int abort_grp);
    int idx, timer, stall_n;
    bit waiting, finished, stop, abused;
    idx = 0; timer = 0; stall_n = 0;
    waiting = 0; finished = 0; stop = 0; abused = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 30000 && !finished && !stop; cyc++) begin
      tile_done  = 1'b0;
      tile_ready = 1'b0;
      start      = 1'b0;
      if (done) begin
        finished = 1;
        chk("handshake_total", idx, exp_a.size());
        chk("busy_in_fin", busy, 0);
      end else if (waiting) begin
        chk("valid_low_in_wait", tile_valid, 0);
        chk("tiling_held_in_wait", count_tiling, exp_a[idx-1].tiling);
        if (abort_grp >= 0 && int'(count_filter) == abort_grp) begin
          rst_n = 1'b0;
          #1;
          chk_all_zero("abort");
          for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("no_done_in_reset", done, 0);
          end
          rst_n = 1'b1;
          stop = 1;
        end else begin
          if (abuse_idx == idx - 1 && !abused) begin
            start  = 1'b1;
            abused = 1;
            chk("busy_at_abuse", busy, 1);
          end
          timer--;
          if (timer <= 0) begin
            tile_done = 1'b1;
            waiting   = 0;
          end
        end
      end else if (tile_valid) begin
        if (idx == stall_idx && stall_n < 20) begin
          stall_n++;
          tile_done = (stall_n % 4 == 1);
          chk("stall_tiling", count_tiling, exp_a[idx].tiling);
          chk("stall_col_base", tile_col_base, exp_a[idx].colb);
          chk("stall_row", tile_row, exp_a[idx].row);
        end else begin
          tile_ready = ($urandom_range(99) < ready_pct);
          if (spur_pct > 0 && $urandom_range(99) < spur_pct) tile_done = 1'b1;
          if (tile_ready) begin
            if (idx < exp_a.size()) chk_desc(idx);
            else chk("extra_handshake", idx, exp_a.size() - 1);
            idx++;
            waiting = 1;
            timer = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(4, 1));
          end
        end
      end else begin
        chk("valid_expected", tile_valid, 1);
        stop = 1;
      end
      @(posedge clk); #1;
    end
    tile_done  = 1'b0;
    tile_ready = 1'b0;
    start      = 1'b0;
    chk("layer_completes", finished | (abort_grp >= 0 && stop), 1);
    chk("done_single_pulse", done, 0);
    chk("busy_after_layer", busy, 0);
  endtask

  initial begin
    int  idx;
    bit  fin, wt;
    rst_n = 1'b0;
    start = 1'b0; tile_ready = 1'b0; tile_done = 1'b0;
    b_start = 1'b0; b_tile_ready = 1'b1; b_tile_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    // tile_done in IDLE must not move anything.
    tile_done = 1'b1;
    @(posedge clk); #1;
    tile_done = 1'b0;
    chk_all_zero("idle_done_ignored");

    build_model(16, 26, 1, 255);
    exp_a = model_q;

    run_a(100, 3, 0, -1, -1, -1);
    run_a(100, 3, 0, 5, 10, -1);
    run_a(60, 0, 30, -1, -1, -1);
    run_a(100, 2, 0, -1, -1, 3);
    run_a(70, 0, 20, -1, -1, -1);

    build_model(16, 16, 3, 32);
    exp_b = model_q;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    idx = 0; fin = 0; wt = 0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      b_tile_done = 1'b0;
      if (b_done) begin
        fin = 1;
        chk("b_handshake_total", idx, exp_b.size());
      end else if (wt) begin
        b_tile_done = 1'b1;
        wt = 0;
      end else if (b_tile_valid && idx < exp_b.size()) begin
        chk("b_row", b_tile_row, exp_b[idx].row);
        chk("b_col_base", b_tile_col_base, exp_b[idx].colb);
        chk("b_cols", b_tile_cols, exp_b[idx].cols);
        chk("b_filter_base", b_filter_base, exp_b[idx].fb);
        chk("b_filter_cnt", b_filter_cnt, exp_b[idx].fc);
        chk("b_count_tiling", b_count_tiling, exp_b[idx].tiling);
        chk("b_count_filter", b_count_filter, exp_b[idx].grp);
        idx++;
        wt = 1;
      end
      @(posedge clk); #1;
    end
    b_tile_done = 1'b0;
    chk("b_layer_completes", fin, 1);
    chk("b_busy_after", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_tile_scheduler.md
Name: conv_tile_scheduler

Overview:
- Sequences one convolution layer on the SYSTOLIC_SIZE x SYSTOLIC_SIZE systolic array.
- Walks filter groups (outer loop), then output rows, then column tiles within a row (inner loop).
- Issues one tile descriptor at a time to the compute/write-back path with a valid/ready handshake.
- Waits for that tile's completion before issuing the next, and pulses done after the last tile of the last filter group completes.

Parameters:
- SYSTOLIC_SIZE, 16, array dimension: output columns per tile and filters per group.
- IFM_SIZE, 26, input feature map height/width.
- KERNEL_SIZE, 1, square kernel size, stride 1, no padding.
- NO_FILTER, 255, number of output channels.
- Derived localparams:
  - OFM_SIZE_CONV = IFM_SIZE-KERNEL_SIZE+1
  - NO_TILING_PER_LINE = ceil(OFM_SIZE_CONV/SYSTOLIC_SIZE)
  - NO_TILING = NO_TILING_PER_LINE*OFM_SIZE_CONV
  - NO_FILTER_GROUP = ceil(NO_FILTER/SYSTOLIC_SIZE)

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin layer; sampled only in IDLE.
- tile_valid  out  1  descriptor valid.
- tile_ready  in  1  engine accepts descriptor.
- tile_row  out  16  output row of the current tile, 0..OFM_SIZE_CONV-1.
- tile_col_base  out  16  first output column of the tile.
- tile_cols  out  16  valid columns in the tile, 1..SYSTOLIC_SIZE.
- filter_base  out  16  first filter index of the group.
- filter_cnt  out  16  valid filters in the group, 1..SYSTOLIC_SIZE.
- count_tiling  out  16  linear tile index within the group, 0..NO_TILING-1.
- count_filter  out  16  filter group index, 0..NO_FILTER_GROUP-1.
- tile_done  in  1  engine finished the outstanding tile (one-cycle pulse).
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final tile_done.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE:
  - On start=1: clear counters, set busy=1, go to ISSUE on the next cycle.
  - tile_done is ignored.
- ISSUE:
  - tile_valid=1 and all descriptor outputs stable.
  - Handshake completes on a cycle with tile_valid & tile_ready; next state WAIT; tile_valid=0 from the following cycle.
  - tile_ready low stalls indefinitely with outputs held.
- WAIT:
  - tile_valid=0. Descriptor outputs hold their values until the next ISSUE.
  - On tile_done=1, advance counters:
    - Column tile increments; on wrap at NO_TILING_PER_LINE, row increments.
    - On row wrap at OFM_SIZE_CONV, filter group increments.
    - count_tiling increments and resets to 0 on group change.
  - If the completed tile was the last of the last group, go to FIN; otherwise go to ISSUE.
  - Minimum issue-to-issue spacing: handshake cycle + 1 (tile_done may arrive the cycle after the handshake).
- FIN:
  - done=1 for exactly one cycle, busy=0.
  - Next state IDLE; counters stay at their final values.
- Descriptor arithmetic:
  - tile_col_base = col_tile*SYSTOLIC_SIZE.
  - tile_cols = min(SYSTOLIC_SIZE, OFM_SIZE_CONV-tile_col_base).
  - filter_base = count_filter*SYSTOLIC_SIZE.
  - filter_cnt = min(SYSTOLIC_SIZE, NO_FILTER-filter_base).
  - All values are registered and updated in the same cycle as the counters.
- Boundary conditions:
  - start while busy: ignored.
  - tile_done in IDLE, ISSUE or FIN: ignored, no counter change.
  - tile_done and tile_ready asserted together in ISSUE: only the handshake takes effect.
  - rst_n low at any time: immediate return to the reset values; an in-flight tile is abandoned and no done is produced.
- Total handshakes per layer = NO_TILING*NO_FILTER_GROUP.

Test Plan:
- Defaults (26/1/255), tile_ready tied 1, tile_done 3 cycles after each handshake:
  - exactly 832 handshakes (52 tiles x 16 groups);
  - every row gives col_base {0,16} with tile_cols {16,10};
  - last group has filter_base=240, filter_cnt=15;
  - single done pulse, busy low afterwards.
- IFM_SIZE=16, KERNEL_SIZE=3, NO_FILTER=32:
  - OFM 14, one tile per line with tile_cols=14;
  - 14 tiles x 2 groups = 28 handshakes, both groups filter_cnt=16.
- Stall: hold tile_ready=0 for 20 cycles on tile 5:
  - tile_valid stays 1 and descriptor is unchanged;
  - extra tile_done pulses during the stall do not advance count_tiling.
- Start abuse: pulse start at tile 10 while busy:
  - counters unaffected; a start 1 cycle after done begins a new layer from tile 0/group 0.
- Reset mid-run: drop rst_n during WAIT of group 3:
  - all outputs 0 asynchronously, no done;
  - a fresh start yields count_filter=0, count_tiling=0.
- Wrap check at row end of default layer (count_tiling 51 -> group change):
  - next descriptor is row 0, col_base 0, count_tiling 0, count_filter incremented by 1.
